fetch_unit: RTL and testbench

Instruction-fetch stage of the five-stage pipeline processor: owns the PC, issues requests to instruction memory over a ready/valid handshake, buffers returned words in a small prefetch FIFO, and drives the IF/ID pipeline register (`instrD`, `PCPlus4D`) consumed by decode. It sits directly upstream of ID and takes branch/jump redirects from EX (`ALU_TargetAddrE`), discarding wrong-path fetches.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, constants and the IF/ID register layout for the instruction-fetch stage.
package fetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [ADDR_W-1:0]  PC_STEP    = 32'd4;
  localparam logic [ADDR_W-1:0]  ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc4;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } ifid_t;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO with flush; DEPTH must be a power of two.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = INSTR_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [W-1:0]           o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;
  logic                    w_do_push;
  logic                    w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC ownership, credit-limited imem requests, prefetch buffering,
// wrong-path response dropping and the IF/ID register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                DEPTH    = 4
) (
  input  logic               Clk,
  input  logic               Rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               stallD,
  output logic [INSTR_W-1:0] instrD,
  output logic [ADDR_W-1:0]  PCPlus4D,
  output logic               validD
);

  localparam int              CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0]  CREDITS = (CNT_W+1)'(DEPTH);

  logic              r_active;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_deliver_pc;
  logic [CNT_W-1:0]  r_outstanding;
  logic [CNT_W-1:0]  r_drop_cnt;
  ifid_t             r_ifid;

  logic [ADDR_W-1:0]  w_target;
  logic               w_credit_ok;
  logic               w_accept;
  logic               w_live;
  logic               w_load;
  logic               w_pop;
  logic               w_bypass;
  logic               w_push;
  logic [CNT_W-1:0]   w_out_nxt;
  logic [CNT_W-1:0]   w_drop_nxt;
  ifid_t              w_ifid_nxt;
  logic [INSTR_W-1:0] w_fifo_data;
  logic [CNT_W-1:0]   w_fifo_count;
  logic               w_fifo_empty;
  logic               w_fifo_full;

  assign w_target    = redirect_pc & ALIGN_MASK;
  assign w_credit_ok = !w_fifo_full &&
                       (({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < CREDITS);

  // r_active keeps the request low while in reset; it rises on the first edge after release.
  assign imem_req  = r_active && !redirect && w_credit_ok;
  assign imem_addr = r_fetch_pc;
  assign w_accept  = imem_req && imem_ready;

  assign w_live    = imem_rvalid && (r_drop_cnt == '0);
  assign w_load    = !r_ifid.valid || !stallD;
  assign w_pop     = !redirect && w_load && !w_fifo_empty;
  assign w_bypass  = !redirect && w_load && w_fifo_empty && w_live;
  assign w_push    = !redirect && w_live && !w_bypass;
  assign w_out_nxt = r_outstanding + CNT_W'(w_accept) - CNT_W'(imem_rvalid);

  // Everything still in flight after a redirect belongs to the old path.
  always_comb begin
    w_drop_nxt = r_drop_cnt;
    if (redirect)
      w_drop_nxt = w_out_nxt;
    else if (imem_rvalid && (r_drop_cnt != '0))
      w_drop_nxt = r_drop_cnt - CNT_W'(1);
  end

  always_comb begin
    w_ifid_nxt = r_ifid;
    if (redirect) begin
      w_ifid_nxt.instr = NOP_INSTR;
      w_ifid_nxt.valid = 1'b0;
    end else if (w_load) begin
      if (w_pop || w_bypass) begin
        w_ifid_nxt.instr = w_pop ? w_fifo_data : imem_rdata;
        w_ifid_nxt.pc4   = pc_next(r_deliver_pc);
        w_ifid_nxt.valid = 1'b1;
      end else begin
        w_ifid_nxt.instr = NOP_INSTR;
        w_ifid_nxt.valid = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_active      <= 1'b0;
      r_fetch_pc    <= RESET_PC;
      r_deliver_pc  <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_ifid        <= '{pc4: '0, instr: NOP_INSTR, valid: 1'b0};
    end else begin
      r_active      <= 1'b1;
      r_outstanding <= w_out_nxt;
      r_drop_cnt    <= w_drop_nxt;
      r_ifid        <= w_ifid_nxt;
      if (redirect) begin
        r_fetch_pc   <= w_target;
        r_deliver_pc <= w_target;
      end else begin
        if (w_accept)           r_fetch_pc   <= pc_next(r_fetch_pc);
        if (w_pop || w_bypass)  r_deliver_pc <= pc_next(r_deliver_pc);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (INSTR_W)
  ) u_fifo (
    .i_clk   (Clk),
    .i_rst_n (Rst_n),
    .i_push  (w_push),
    .i_data  (imem_rdata),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign instrD   = r_ifid.instr;
  assign PCPlus4D = r_ifid.pc4;
  assign validD   = r_ifid.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order, fixed-latency, addr-as-data memory.
module tb_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = '0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stallD;
  logic [31:0] instrD;
  logic [31:0] PCPlus4D;
  logic        validD;

  int n_chk  = 0;
  int n_pass = 0;

  fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(4)) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stallD      (stallD),
    .instrD      (instrD),
    .PCPlus4D    (PCPlus4D),
    .validD      (validD)
  );

  always #5 Clk = ~Clk;

  // Memory: accepts sampled on the rising edge, response presented after the falling
  // edge that precedes edge (accept_edge + mem_lat).
  typedef struct { logic [31:0] addr; int due; } rsp_t;
  rsp_t rq[$];
  int   edge_n  = 0;
  int   mem_lat = 1;

  always @(Clk) begin
    if (Clk) begin
      edge_n = edge_n + 1;
      if (!Rst_n) rq.delete();
      else if (imem_req && imem_ready) rq.push_back('{imem_addr, edge_n + mem_lat});
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (Rst_n && rq.size() > 0 && rq[0].due <= edge_n + 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = rq[0].addr;
        void'(rq.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s got=%h want=%h", tag, obs, exp);
  endtask

  task automatic do_reset(input int lat);
    #1;
    Rst_n    = 1'b0;
    redirect = 1'b0;
    stallD   = 1'b0;
    #1;
    chk("async_rst_req",   imem_req,  32'h0);
    chk("async_rst_valid", validD,    32'h0);
    chk("async_rst_instr", instrD,    32'h0);
    chk("async_rst_pc4",   PCPlus4D,  32'h0);
    chk("async_rst_addr",  imem_addr, 32'h100);
    mem_lat = lat;
    tick();
    tick();
    Rst_n = 1'b1;
  endtask

  logic [31:0] exp_pc;
  logic        ld;
  logic        found;

  initial begin
    Rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; stallD = 1'b0; imem_ready = 1'b1;
    tick(); tick();
    chk("rst_req",   imem_req, 32'h0);
    chk("rst_valid", validD,   32'h0);
    chk("rst_instr", instrD,   32'h0);
    chk("rst_pc4",   PCPlus4D, 32'h0);
    Rst_n = 1'b1;

    // Streaming with 1-cycle memory
    tick();
    chk("c0_req",   imem_req,  32'h1);
    chk("c0_addr",  imem_addr, 32'h100);
    chk("c0_valid", validD,    32'h0);
    tick();
    chk("c1_valid", validD, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("seq_valid", validD,   32'h1);
      chk("seq_instr", instrD,   32'h100 + 4*i);
      chk("seq_pc4",   PCPlus4D, 32'h104 + 4*i);
    end

    // Three-cycle stall: hold, credit cap, gap-free resume
    stallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold",  instrD, 32'h10C);
      chk("stall_valid", validD, 32'h1);
    end
    chk("credit_cap", imem_req, 32'h0);
    stallD = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("resume_instr", instrD,   32'h110 + 4*i);
      chk("resume_pc4",   PCPlus4D, 32'h114 + 4*i);
    end

    // Redirect with three requests in flight, 3-cycle memory
    do_reset(3);
    tick();
    chk("l3_c0_addr", imem_addr, 32'h100);
    tick(); tick(); tick();
    chk("l3_fill_valid", validD, 32'h0);
    tick();
    chk("l3_first", instrD, 32'h100);
    redirect = 1'b1; redirect_pc = 32'h2003;
    #1;
    chk("redir_no_req", imem_req, 32'h0);
    tick();
    chk("redir_bubble", validD, 32'h0);
    redirect = 1'b0;
    #1;
    chk("redir_req",  imem_req,  32'h1);
    chk("redir_addr", imem_addr, 32'h2000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drop_bubble", validD, 32'h0);
    end
    tick();
    chk("tgt_valid", validD,   32'h1);
    chk("tgt_instr", instrD,   32'h2000);
    chk("tgt_pc4",   PCPlus4D, 32'h2004);
    tick();
    chk("tgt_next", instrD, 32'h2004);

    // Redirect + stall on the same cycle as a live response
    redirect = 1'b1; stallD = 1'b1; redirect_pc = 32'h3000;
    tick();
    chk("rs_valid", validD, 32'h0);
    chk("rs_instr", instrD, 32'h0);
    redirect = 1'b0; stallD = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rs_drop_bubble", validD, 32'h0);
    end
    tick();
    chk("rs_tgt_instr", instrD,   32'h3000);
    chk("rs_tgt_pc4",   PCPlus4D, 32'h3004);
    tick();
    chk("rs_tgt_next", instrD, 32'h3004);

    // Address wrap at the top of memory
    do_reset(1);
    tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    chk("wrap_bubble", validD, 32'h0);
    redirect = 1'b0;
    #1;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
    tick();
    chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_instr0", instrD,    32'hFFFF_FFF8);
    chk("wrap_pc4_0",  PCPlus4D,  32'hFFFF_FFFC);
    chk("wrap_addr2",  imem_addr, 32'h0);
    tick();
    chk("wrap_instr1", instrD,   32'hFFFF_FFFC);
    chk("wrap_pc4_1",  PCPlus4D, 32'h0);
    tick();
    chk("wrap_instr2", instrD,   32'h0);
    chk("wrap_pc4_2",  PCPlus4D, 32'h4);
    chk("wrap_valid2", validD,   32'h1);

    // Random ready and stall: delivered stream stays sequential; then reset mid-stream
    do_reset(2);
    exp_pc = 32'h100;
    for (int i = 0; i < 40; i++) begin
      imem_ready = 1'($urandom_range(0, 1));
      stallD     = ($urandom_range(0, 3) == 0);
      ld         = !validD || !stallD;
      tick();
      if (ld && validD) begin
        chk("rnd_instr", instrD,   exp_pc);
        chk("rnd_pc4",   PCPlus4D, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
      end else if (!ld) begin
        chk("rnd_hold", instrD, exp_pc - 32'd4);
      end
    end
    do_reset(2);
    tick();
    chk("restart_req",  imem_req,  32'h1);
    chk("restart_addr", imem_addr, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      imem_ready = 1'($urandom_range(0, 1));
      tick();
      if (validD) found = 1'b1;
    end
    chk("restart_found", found,    32'h1);
    chk("restart_instr", instrD,   32'h100);
    chk("restart_pc4",   PCPlus4D, 32'h104);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
